// File: rtl/seq_det_moore_param.sv
// rtl/seq_det_moore_param.sv - parametrised Moore serial pattern detector; match counter built only with SEQ_DET_MATCH_CNT_EN
module seq_det_moore_param #(
  parameter int unsigned          PAT_W   = 4,
  parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_i,
  input  logic             valid_i,
  input  logic             mode_i,
  input  logic             clear_i,
  output logic             det_o,
  output logic [CNT_W-1:0] match_cnt_o
);

  localparam int unsigned     FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  win_q,  win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q,  det_d;

  logic [PAT_W-1:0]  win_acc;
  logic [FILL_W-1:0] fill_acc;
  logic              hit;

  // Candidate history/fill if this edge accepts a bit; match is judged on these next-state values
  always_comb begin
    win_acc  = (win_q << 1) | {{(PAT_W-1){1'b0}}, in_i};
    fill_acc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    hit      = valid_i && !clear_i && (win_acc == PATTERN) && (fill_acc == FILL_FULL);
  end

  // Next-state for history, fill and the detect flag; clear wins over an accepted bit
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (clear_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (valid_i) begin
      win_d  = win_acc;
      fill_d = fill_acc;
      if (hit) begin
        det_d = 1'b1;
        // Non-overlapping: demand a fresh full pattern before the next match
        if (!mode_i) begin
          win_d  = '0;
          fill_d = '0;
        end
      end
    end
  end

  // Detector state registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_q  <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  assign det_o = det_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; never wraps, cleared together with the detector
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Match counter register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;
`else
  assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_seq_det_moore_param.sv
// tb/tb_seq_det_moore_param.sv - self-checking bench for seq_det_moore_param (honours SEQ_DET_MATCH_CNT_EN)
module tb_seq_det_moore_param;

  localparam int unsigned      PAT_W = 4;
  localparam logic [PAT_W-1:0] PAT   = 4'b1011;
  localparam int unsigned      CNT_W = 8;
  localparam int unsigned      SAT_W = 2;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             in_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             det_o, det_sat_o;
  logic [CNT_W-1:0] cnt_o;
  logic [SAT_W-1:0] cnt_sat_o;

  always #5 clk = ~clk;

  seq_det_moore_param #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_i), .valid_i(valid_i),
    .mode_i(mode_i), .clear_i(clear_i), .det_o(det_o), .match_cnt_o(cnt_o)
  );

  seq_det_moore_param #(.PAT_W(PAT_W), .PATTERN(PAT), .CNT_W(SAT_W)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_i), .valid_i(valid_i),
    .mode_i(mode_i), .clear_i(clear_i), .det_o(det_sat_o), .match_cnt_o(cnt_sat_o)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: list of bits accepted since the last restart, plus match totals
  logic        hist[$];
  logic        m_det;
  int unsigned m_cnt, m_cnt_sat;

  function automatic void model_reset();
    hist.delete();
    m_det = 1'b0;
    m_cnt = 0;
    m_cnt_sat = 0;
  endfunction

  function automatic void model_step(input logic b, input logic v, input logic m, input logic c);
    bit match;
    if (!rst_i) begin
      model_reset();
      return;
    end
    m_det = 1'b0;
    if (c) begin
      model_reset();
    end else if (v) begin
      hist.push_back(b);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      match = (hist.size() == PAT_W);
      for (int i = 0; i < PAT_W; i++)
        if (match && hist[i] != PAT[PAT_W-1-i]) match = 0;
      if (match) begin
        m_det = 1'b1;
        if (m_cnt < (2**CNT_W) - 1) m_cnt++;
        if (m_cnt_sat < (2**SAT_W) - 1) m_cnt_sat++;
        if (!m) hist.delete();
      end
    end
  endfunction

  function automatic int unsigned exp_cnt(input int unsigned v);
`ifdef SEQ_DET_MATCH_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".det"}, 32'(det_o), 32'(m_det));
    chk({tag, ".det_sat"}, 32'(det_sat_o), 32'(m_det));
    chk({tag, ".cnt"}, 32'(cnt_o), exp_cnt(m_cnt));
    chk({tag, ".cnt_sat"}, 32'(cnt_sat_o), exp_cnt(m_cnt_sat));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, sample 1 unit later
  task automatic step(input logic b, input logic v, input logic m, input logic c);
    @(negedge clk);
    in_i = b; valid_i = v; mode_i = m; clear_i = c;
    @(posedge clk);
    model_step(b, v, m, c);
    #1;
  endtask

  task automatic async_reset_pulse();
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    chk("async_rst.det", 32'(det_o), 32'd0);
    chk("async_rst.cnt", 32'(cnt_o), 32'd0);
    #2 rst_i = 1'b1;
  endtask

  typedef struct {
    logic b;
    logic v;
    logic m;
    logic c;
    logic exp_det;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic b, input logic v, input logic m, input logic c, input logic e);
    vec_t r;
    r.b = b; r.v = v; r.m = m; r.c = c; r.exp_det = e;
    vecs.push_back(r);
  endfunction

  initial begin
    logic        cur_mode;
    logic [15:0] sat_stream;

    // Non-overlap 1011011: one match after bit 4
    add(1,1,0,0,0); add(0,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,1);
    add(0,1,0,0,0); add(1,1,0,0,0); add(1,1,0,0,0); add(0,0,0,0,0);
    // Overlap 1011011 from a cleared start: matches after bits 4 and 7
    add(0,0,1,1,0);
    add(1,1,1,0,0); add(0,1,1,0,0); add(1,1,1,0,0); add(1,1,1,0,1);
    add(0,1,1,0,0); add(1,1,1,0,0); add(1,1,1,0,1); add(0,0,1,0,0);
    // Valid gaps: 1,(gap x3),0,1,(gap),1 -> single pulse after the last accepted bit
    add(0,0,0,1,0);
    add(1,1,0,0,0); add(0,0,0,0,0); add(1,0,0,0,0); add(0,0,0,0,0);
    add(0,1,0,0,0); add(1,1,0,0,0); add(0,0,0,0,0); add(1,1,0,0,1);
    add(1,0,0,0,0); add(0,0,0,0,0);
    // Saturation stream in overlap mode: pulses after bits 4,7,10,13,16
    add(0,0,1,1,0);
    sat_stream = 16'b1011011011011011;
    for (int i = 15; i >= 0; i--) begin
      int pos;
      pos = 16 - i;
      add(sat_stream[i], 1, 1, 0, (pos >= 4 && (pos - 4) % 3 == 0) ? 1'b1 : 1'b0);
    end

    model_reset();
    // Reset held for two cycles with activity on the inputs
    for (int i = 0; i < 2; i++) begin
      step(logic'(i), 1'b1, 1'b0, 1'b0);
      chk("rst_hold.det", 32'(det_o), 32'd0);
      chk("rst_hold.cnt", 32'(cnt_o), 32'd0);
    end
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst.det", 32'(det_o), 32'd0);
      chk("post_rst.cnt", 32'(cnt_o), 32'd0);
    end

    // Directed table
    foreach (vecs[i]) begin
      step(vecs[i].b, vecs[i].v, vecs[i].m, vecs[i].c);
      chk($sformatf("vec%0d.det", i), 32'(det_o), 32'(vecs[i].exp_det));
      chk_model($sformatf("vec%0d", i));
    end
    chk("sat_final.cnt_sat", 32'(cnt_sat_o), exp_cnt(3));
    chk("sat_final.cnt", 32'(cnt_o), exp_cnt(5));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_still_pulses_then_low", 32'(det_sat_o), 32'd0);

    // Clear mid-pattern: 1,0,1 then clear with a simultaneous bit that must be dropped
    step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
    step(1,1,0,1);
    chk("clear.det", 32'(det_o), 32'd0);
    chk("clear.cnt", 32'(cnt_o), 32'd0);
    chk("clear.cnt_sat", 32'(cnt_sat_o), 32'd0);
    step(1,1,0,0);
    chk("clear_then_1.det", 32'(det_o), 32'd0);
    step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
    chk("clear_seq_pre.det", 32'(det_o), 32'd0);
    step(1,1,0,0);
    chk("clear_seq.det", 32'(det_o), 32'd1);
    chk("clear_seq.cnt", 32'(cnt_o), exp_cnt(1));

    // Asynchronous reset mid-pattern
    step(0,0,0,0);
    step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
    async_reset_pulse();
    step(1,1,0,0);
    chk("rst_then_1.det", 32'(det_o), 32'd0);
    step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
    step(1,1,0,0);
    chk("rst_seq.det", 32'(det_o), 32'd1);
    chk_model("rst_seq");

    // Randomised traffic against the model
    cur_mode = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0), cur_mode,
           logic'($urandom_range(0, 49) == 0));
      chk_model($sformatf("rand%0d", i));
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
